// File: rtl/meter_pkg.sv
// Shared definitions for the parking-meter controller.
// Holds the meter state encoding, the time-value width, the add amounts
// selected by step_option and the two preset values selected by hold_option.
package meter_pkg;

  localparam int TIME_W = 14;

  typedef enum logic [1:0] {
    EXPIRED = 2'd0,
    LOW     = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Add amounts carry one extra bit so sums can exceed the ceiling before
  // saturation is applied.
  localparam logic [TIME_W:0] ADD_STEP0 = 15'd10;
  localparam logic [TIME_W:0] ADD_STEP1 = 15'd180;
  localparam logic [TIME_W:0] ADD_STEP2 = 15'd200;
  localparam logic [TIME_W:0] ADD_STEP3 = 15'd550;

  localparam logic [TIME_W-1:0] PRESET_SHORT = 14'd15;
  localparam logic [TIME_W-1:0] PRESET_LONG  = 14'd150;

  // Total seconds requested by the set step_option bits in one cycle.
  function automatic logic [TIME_W:0] step_sum(input logic [3:0] step);
    logic [TIME_W:0] acc;
    acc = '0;
    if (step[0]) acc = acc + ADD_STEP0;
    if (step[1]) acc = acc + ADD_STEP1;
    if (step[2]) acc = acc + ADD_STEP2;
    if (step[3]) acc = acc + ADD_STEP3;
    return acc;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : request; accepted when idle, bin is captured on that edge
//   bin        : 14-bit binary value to convert
//   busy       : high from the capture edge until the result is published
//   done       : one-cycle pulse alongside the bcd update
//   bcd        : four BCD digits, changes only when done rises
module bin2bcd_seq
  import meter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [TIME_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [15:0]       bcd
);

  localparam logic [3:0] LAST_ITER = 4'(TIME_W);

  logic [TIME_W-1:0] bin_sh;
  logic [15:0]       bcd_sh;
  logic [15:0]       bcd_adj;
  logic [3:0]        iter;

  // Any digit of 5 or more gets +3 so the following shift carries correctly.
  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    bcd_adj = add3(bcd_sh);
  end

  // Control: capture, iterate TIME_W times, then publish and pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      iter <= '0;
      bcd  <= 16'h0000;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          iter <= '0;
        end
      end else if (iter == LAST_ITER) begin
        busy <= 1'b0;
        done <= 1'b1;
        bcd  <= bcd_sh;
      end else begin
        iter <= iter + 4'd1;
      end
    end
  end

  // Datapath shift register.
  always_ff @(posedge clk) begin
    if (!busy && start) begin
      bin_sh <= bin;
      bcd_sh <= '0;
    end else if (busy && iter != LAST_ITER) begin
      {bcd_sh, bin_sh} <= {bcd_adj[14:0], bin_sh, 1'b0};
    end
  end

endmodule

// File: rtl/meter_controller.sv
// Parking-meter countdown controller.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   step_option : one-cycle add pulses (+10, +180, +200, +550 s)
//   hold_option : [0] preset 15 s, [1] preset 150 s, [2] pause countdown
//   bcd_value   : remaining time as four BCD digits
//   flash_slow  : blink request while expired (half-second duty)
//   flash_fast  : blink request on even seconds in the low-time warning
//   time_bin    : remaining time in binary seconds
//   conv_busy   : high while the BCD conversion is running
module meter_controller
  import meter_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int LOW_THRESH = 200,
  parameter int MAX_TIME   = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        step_option,
  input  logic [2:0]        hold_option,
  output logic [15:0]       bcd_value,
  output logic              flash_slow,
  output logic              flash_fast,
  output logic [TIME_W-1:0] time_bin,
  output logic              conv_busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]     PRE_HALF = PW'(TICK_DIV / 2);
  localparam logic [PW-1:0]     PRE_ONE  = PW'(1);
  localparam logic [TIME_W:0]   MAX_W    = (TIME_W + 1)'(MAX_TIME);
  localparam logic [TIME_W-1:0] LOW_W    = TIME_W'(LOW_THRESH);
  localparam logic [TIME_W-1:0] T_ONE    = TIME_W'(1);

  logic [PW-1:0]     pres;
  logic [PW-1:0]     pres_next;
  logic [TIME_W:0]   sum;
  logic [TIME_W-1:0] sat;
  logic [TIME_W-1:0] time_next;
  logic              preset;
  logic              tick;
  logic              time_change;
  logic              accept;
  state_t            state;
  state_t            state_next;
  logic              conv_start;
  logic              pending;
  logic              conv_done;

  // Next-time computation: preset beats add, add beats tick. With no add
  // bits set the saturated sum is simply the current time.
  always_comb begin
    preset    = hold_option[0] | hold_option[1];
    tick      = !hold_option[2] && (pres == PRE_LAST);
    sum       = {1'b0, time_bin} + step_sum(step_option);
    sat       = (sum > MAX_W) ? MAX_W[TIME_W-1:0] : sum[TIME_W-1:0];
    time_next = sat;
    pres_next = pres;
    if (preset) begin
      time_next = hold_option[0] ? PRESET_SHORT : PRESET_LONG;
      pres_next = '0;
    end else begin
      if (tick && sat != '0) time_next = sat - T_ONE;
      if (!hold_option[2]) pres_next = tick ? '0 : pres + PRE_ONE;
    end
    time_change = (time_next != time_bin);
    accept      = conv_start && !conv_busy;
  end

  // State follows the value time_bin is about to take; flashes derive from
  // the registered state so they line up with the registered time.
  always_comb begin
    state_next = RUN;
    if (time_next == '0)       state_next = EXPIRED;
    else if (time_next < LOW_W) state_next = LOW;
    flash_slow = 1'b0;
    flash_fast = 1'b0;
    case (state)
      EXPIRED: flash_slow = (pres >= PRE_HALF);
      LOW:     flash_fast = ~time_bin[0];
      default: ;
    endcase
  end

  // Registered time, prescaler, state and conversion handshake. A change
  // that lands while a conversion is running (or on the edge it captures)
  // is remembered in pending and re-requested once done arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      time_bin   <= '0;
      pres       <= '0;
      state      <= EXPIRED;
      conv_start <= 1'b0;
      pending    <= 1'b0;
    end else begin
      time_bin <= time_next;
      pres     <= pres_next;
      state    <= state_next;
      if (time_change && (conv_busy || accept)) pending <= 1'b1;
      if (time_change && !conv_busy && !accept) conv_start <= 1'b1;
      else if (conv_busy)                       conv_start <= 1'b0;
      if (conv_done && pending) begin
        conv_start <= 1'b1;
        pending    <= 1'b0;
      end
    end
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (time_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd_value)
  );

endmodule

// File: doc/meter_controller.md
METER_CONTROLLER -- requirements
Module: meter_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per 1 s countdown tick.
REQ-002 SHALL have parameter LOW_THRESH, default 200, meaning the low-time warning threshold in seconds.
REQ-003 SHALL have parameter MAX_TIME, default 9999, meaning the saturation ceiling in seconds.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port step_option  input  4  one-cycle add pulses: [0] +10, [1] +180, [2] +200, [3] +550 s.
REQ-007 SHALL have port hold_option  input  3  [0] level: preset 15 s; [1] level: preset 150 s; [2] level: pause countdown.
REQ-008 SHALL have port bcd_value  output  16  four BCD digits of remaining time; digit 3 in [15:12].
REQ-009 SHALL have port flash_slow  output  1  blank request while expired.
REQ-010 SHALL have port flash_fast  output  1  blank request while in low-time warning.
REQ-011 SHALL have port time_bin  output  14  remaining time in binary seconds.
REQ-012 SHALL have port conv_busy  output  1  high while the BCD conversion runs.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1; tick is high for exactly one cycle when count = TICK_DIV-1, then count wraps to 0.
REQ-014 While hold_option[2]=1, prescaler SHALL freeze and no tick SHALL occur.
REQ-015 Per-cycle update priority: preset > add > tick.
REQ-016 Preset: hold_option[0]=1 loads 15; else hold_option[1]=1 loads 150; prescaler clears to 0; adds and ticks that cycle are discarded.
REQ-017 Add: time_bin <= min(time_bin + sum of all set step_option amounts, MAX_TIME), with 15-bit intermediate width.
REQ-018 Tick in the same cycle as an add SHALL decrement the saturated sum by 1 when that sum > 0.
REQ-019 Tick with time_bin = 0 SHALL leave it at 0; there is no wrap-around.
REQ-020 FSM states: EXPIRED (time_bin = 0), LOW (1 <= time_bin < LOW_THRESH), RUN (time_bin >= LOW_THRESH); state is re-evaluated every cycle from next time_bin.
REQ-021 flash_slow SHALL be 1 only in EXPIRED and prescaler count >= TICK_DIV/2 (0.5 s on / 0.5 s off).
REQ-022 flash_fast SHALL be 1 only in LOW and time_bin[0] = 0 (blank on even seconds).
REQ-023 In RUN, both flash outputs SHALL be 0; flash_slow and flash_fast SHALL never be high together.
REQ-024 Any change of time_bin SHALL raise conv_start to the converter; conv_start SHALL be held until conv_busy is seen high.
REQ-025 Converter SHALL be shift-add-3, 14 iterations, one per cycle; done pulse on the cycle after the last iteration; latency from start to bcd_value update is 16 cycles.
REQ-026 bcd_value SHALL change only on done and SHALL hold its prior value during conversion.
REQ-027 A time_bin change during conv_busy SHALL set a pending flag; a new conversion of the latest value SHALL start on the cycle after done; intermediate values may be skipped.

Reset
REQ-028 On reset: time_bin=0, bcd_value=16'h0000, flash_slow=0, flash_fast=0, conv_busy=0, prescaler=0, pending=0, state=EXPIRED.
REQ-029 Reset asserted mid-conversion SHALL abort it, and no done pulse SHALL follow.
REQ-030 Reset SHALL take precedence over presets, adds and ticks.

Structure
REQ-031 Package meter_pkg SHALL hold the state enum, the add amounts (10/180/200/550), the preset values (15/150) and the 14-bit time width.
REQ-032 Conversion SHALL be one sub-module, bin2bcd_seq, with ports clk, reset, start, bin[13:0], busy, done, bcd[15:0].

Verification (bench TICK_DIV=10)
REQ-033 Reset, then step_option=4'b0001 pulse -> time_bin=10 next cycle; bcd_value=16'h0010 16 cycles after the change; flash_fast toggles with time_bin parity.
REQ-034 hold_option=3'b010 with step_option=4'b1000 in the same cycle -> time_bin=150, prescaler=0, add ignored; state RUN=0 flashes until time_bin<200 holds, i.e. immediately LOW.
REQ-035 Preload 9990, pulse 4'b1111 -> time_bin=9999, bcd_value=16'h9999.
REQ-036 time_bin=1, let a tick pass -> 0, EXPIRED; flash_slow high on prescaler counts 5..9 only; further ticks keep 0.
REQ-037 Pulse adds on two consecutive cycles while converting -> one pending re-conversion; final bcd_value matches final time_bin; reset asserted mid-conversion -> bcd_value=0, conv_busy=0 next cycle.
REQ-038 hold_option[2]=1 for 30 cycles at time_bin=300 -> time_bin stays 300; on release, first tick lands TICK_DIV-count cycles later.
